mod12_display: RTL and testbench

//  Display/event stage directly downstream of the mod-12 up/down counter. Samples the 4-bit

---
 rtl/mod12_disp_pkg.sv | 28 ++
 rtl/mod12_display_seg7_encode.sv | 28 ++
 rtl/mod12_display.sv | 160 ++++++++++++++++
 tb/tb_mod12_display.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod12_disp_pkg.sv
// Shared types and constants for the mod-12 display stage: scan-state
// encoding, the counter's terminal value and the 7-segment glyphs
// (active-high, bit6 = a .. bit0 = g).
package mod12_disp_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP_U = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_T = 2'd3
  } scan_state_t;

  localparam logic [3:0] MOD12_MAX = 4'd11;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/mod12_display_seg7_encode.sv
// Combinational BCD digit to 7-segment encoder. Any value above 9 renders
// as 'E' so an out-of-range digit is visibly wrong rather than blank.
module seg7_encode
  import mod12_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_E;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/mod12_display.sv
// Display/event stage behind the mod-12 up/down counter. Samples the count
// every cycle, scans a 2-digit multiplexed 7-segment display with a one-cycle
// blank gap between digits, pulses and toggles AM/PM on every wrap
// (11->0 counting up, 0->11 counting down) and latches a sticky error on any
// count above 11.
// Build option: define MOD12_BLANK_EN to blank a leading-zero tens digit.
module mod12_display
  import mod12_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  input  logic             mode_in,
  output logic [6:0]       seg_out,
  output logic [1:0]       dig_en,
  output logic             ampm,
  output logic             wrap_pulse,
  output logic             err
);

  localparam int             RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);

  logic [3:0]    count_q;
  logic [3:0]    prev_q;
  logic          mode_q;
  logic          samp_seen;
  logic          hist_valid;
  logic          wrap_det;
  logic          over;
  logic          tens;
  logic [3:0]    units_digit;
  logic [3:0]    enc_digit;
  logic [6:0]    enc_seg;
  logic [6:0]    tens_seg;
  scan_state_t   state;
  logic [RW-1:0] refresh_cnt;

  // Input sampling; hist_valid rises once both prev_q and count_q hold real samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      prev_q     <= '0;
      mode_q     <= 1'b0;
      samp_seen  <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      count_q    <= count_in;
      prev_q     <= count_q;
      mode_q     <= mode_in;
      samp_seen  <= 1'b1;
      hist_valid <= samp_seen;
    end
  end

  assign wrap_det = hist_valid &
                    (( mode_q & (prev_q == MOD12_MAX) & (count_q == 4'd0)) |
                     (~mode_q & (prev_q == 4'd0)      & (count_q == MOD12_MAX)));

  // Wrap pulse, AM/PM toggle and sticky out-of-range flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_pulse <= 1'b0;
      ampm       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wrap_pulse <= wrap_det;
      if (wrap_det)
        ampm <= ~ampm;
      if (over)
        err <= 1'b1;
    end
  end

  // Digit split of the sampled count; out-of-range shows 'E' on units only
  always_comb begin
    over        = (count_q > MOD12_MAX);
    tens        = (count_q >= 4'd10);
    units_digit = count_q;
    if (over)
      units_digit = 4'hE;
    else if (tens)
      units_digit = count_q - 4'd10;
    enc_digit = (state == S_TENS) ? {3'b000, tens} : units_digit;
  end

  seg7_encode u_enc (
    .digit (enc_digit),
    .seg   (enc_seg)
  );

  // Tens glyph: blank when out of range, optionally blank a leading zero
  always_comb begin
    tens_seg = enc_seg;
    if (over)
      tens_seg = SEG_BLANK;
`ifdef MOD12_BLANK_EN
    else if (!tens)
      tens_seg = SEG_BLANK;
`else
    else
      tens_seg = enc_seg;
`endif
  end

  // Scan FSM with registered digit enable and segments
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_UNITS;
      refresh_cnt <= '0;
      seg_out     <= SEG_BLANK;
      dig_en      <= 2'b00;
    end else begin
      case (state)
        S_UNITS: begin
          dig_en  <= 2'b01;
          seg_out <= enc_seg;
          if (refresh_cnt == REF_LAST) begin
            state       <= S_GAP_U;
            refresh_cnt <= '0;
          end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        S_GAP_U: begin
          dig_en      <= 2'b00;
          seg_out     <= SEG_BLANK;
          state       <= S_TENS;
          refresh_cnt <= '0;
        end
        S_TENS: begin
          dig_en  <= 2'b10;
          seg_out <= tens_seg;
          if (refresh_cnt == REF_LAST) begin
            state       <= S_GAP_T;
            refresh_cnt <= '0;
          end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
          end
        end
        S_GAP_T: begin
          dig_en      <= 2'b00;
          seg_out     <= SEG_BLANK;
          state       <= S_UNITS;
          refresh_cnt <= '0;
        end
        default: begin
          dig_en      <= 2'b00;
          seg_out     <= SEG_BLANK;
          state       <= S_UNITS;
          refresh_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod12_display.sv
// Directed bench for mod12_display with REFRESH_DIV = 4.
module tb_mod12_display;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] GE = 7'b1001111;
  localparam logic [6:0] GB = 7'b0000000;
`ifdef MOD12_BLANK_EN
  localparam logic [6:0] TENS0 = GB;
`else
  localparam logic [6:0] TENS0 = G0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] count_in;
  logic       mode_in;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic       ampm;
  logic       wrap_pulse;
  logic       err;

  int checks;
  int errors;

  mod12_display #(.REFRESH_DIV(4), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .count_in   (count_in),
    .mode_in    (mode_in),
    .seg_out    (seg_out),
    .dig_en     (dig_en),
    .ampm       (ampm),
    .wrap_pulse (wrap_pulse),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] c, input logic m);
    reset    = 1'b1;
    count_in = c;
    mode_in  = m;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    count_in = 4'd3;
    mode_in  = 1'b1;
    tick();
    tick();
    checks++;
    if ({seg_out, dig_en, ampm, wrap_pulse, err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got seg=%b dig=%b ampm=%b wrap=%b err=%b, want all zero",
               seg_out, dig_en, ampm, wrap_pulse, err);
    end
  endtask

  task automatic test_scan();
    logic [1:0] exp_dig;
    logic [6:0] exp_seg;
    int ph;
    do_reset(4'd7, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      ph = (i - 1) % 10;
      if (ph < 4) begin
        exp_dig = 2'b01;
        exp_seg = (i == 1) ? G0 : G7;
      end else if (ph >= 5 && ph < 9) begin
        exp_dig = 2'b10;
        exp_seg = TENS0;
      end else begin
        exp_dig = 2'b00;
        exp_seg = GB;
      end
      checks++;
      if (dig_en !== exp_dig || seg_out !== exp_seg) begin
        errors++;
        $display("FAIL scan_7 cycle %0d: got dig=%b seg=%b, want dig=%b seg=%b",
                 i, dig_en, seg_out, exp_dig, exp_seg);
      end
    end
  endtask

  task automatic test_wrap_up();
    do_reset(4'd10, 1'b1);
    tick();                       // samples 10
    count_in = 4'd11;
    tick();                       // samples 11
    count_in = 4'd0;
    tick();                       // samples 0
    checks++;
    if (wrap_pulse !== 1'b0 || ampm !== 1'b0) begin
      errors++;
      $display("FAIL wrap_up_early: got wrap=%b ampm=%b, want 0 0", wrap_pulse, ampm);
    end
    tick();
    checks++;
    if (wrap_pulse !== 1'b1 || ampm !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up_pulse: got wrap=%b ampm=%b, want 1 1", wrap_pulse, ampm);
    end
    tick();
    checks++;
    if (wrap_pulse !== 1'b0 || ampm !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up_after: got wrap=%b ampm=%b, want 0 1", wrap_pulse, ampm);
    end
  endtask

  task automatic test_wrap_down();
    int pulses;
    mode_in  = 1'b0;
    count_in = 4'd1;
    tick();
    count_in = 4'd0;
    tick();
    count_in = 4'd11;
    tick();
    checks++;
    if (wrap_pulse !== 1'b0 || ampm !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down_early: got wrap=%b ampm=%b, want 0 1", wrap_pulse, ampm);
    end
    tick();
    checks++;
    if (wrap_pulse !== 1'b1 || ampm !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down_pulse: got wrap=%b ampm=%b, want 1 0", wrap_pulse, ampm);
    end
    pulses = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wrap_pulse) pulses++;
      if (dig_en != 2'b00) begin
        checks++;
        if (seg_out !== G1) begin
          errors++;
          $display("FAIL show_11 dig=%b: got seg=%b, want %b", dig_en, seg_out, G1);
        end
      end
    end
    checks++;
    if (pulses !== 0 || ampm !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down_single: got extra pulses=%0d ampm=%b, want 0 0", pulses, ampm);
    end
  endtask

  task automatic test_err();
    count_in = 4'd13;
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_latency: got err=%b, want 0", err);
    end
    tick();
    checks++;
    if (err !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_set: got err=%b wrap=%b, want 1 0", err, wrap_pulse);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dig_en == 2'b01) begin
        checks++;
        if (seg_out !== GE) begin
          errors++;
          $display("FAIL err_units: got seg=%b, want %b", seg_out, GE);
        end
      end else if (dig_en == 2'b10) begin
        checks++;
        if (seg_out !== GB) begin
          errors++;
          $display("FAIL err_tens: got seg=%b, want %b", seg_out, GB);
        end
      end
    end
    count_in = 4'd5;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: got err=%b, want 1", err);
      end
      if (dig_en == 2'b01) begin
        checks++;
        if (seg_out !== G5) begin
          errors++;
          $display("FAIL show_5_units: got seg=%b, want %b", seg_out, G5);
        end
      end else if (dig_en == 2'b10) begin
        checks++;
        if (seg_out !== TENS0) begin
          errors++;
          $display("FAIL show_5_tens: got seg=%b, want %b", seg_out, TENS0);
        end
      end
    end
  endtask

  task automatic test_reset_mid_tens();
    int n;
    n = 0;
    while (dig_en !== 2'b10 && n < 12) begin
      tick();
      n++;
    end
    checks++;
    if (dig_en !== 2'b10) begin
      errors++;
      $display("FAIL reach_tens: got dig=%b after %0d cycles, want 10", dig_en, n);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (seg_out !== GB || dig_en !== 2'b00 || ampm !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got seg=%b dig=%b ampm=%b err=%b, want 0 00 0 0",
               seg_out, dig_en, ampm, err);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_release_no_wrap();
    do_reset(4'd11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (wrap_pulse !== 1'b0 || ampm !== 1'b0) begin
        errors++;
        $display("FAIL release_no_wrap cycle %0d: got wrap=%b ampm=%b, want 0 0",
                 i, wrap_pulse, ampm);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    count_in = 4'd0;
    mode_in  = 1'b0;
    test_reset();
    test_scan();
    test_wrap_up();
    test_wrap_down();
    test_err();
    test_reset_mid_tens();
    test_release_no_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
